// File: rtl/seq_shift_add_multiplier.sv
// Unsigned sequential shift-and-add multiplier: one operand pair per start,
// full 2*WIDTH-bit product after WIDTH iterations, one-cycle done pulse.
module seq_shift_add_multiplier #(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset_,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned PW = 2 * WIDTH;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state, state_next;
  logic             busy_next, done_next;
  logic [WIDTH-1:0] mcand, mcand_next;
  logic [WIDTH-1:0] acc, acc_next;
  logic [WIDTH-1:0] mplier, mplier_next;
  logic [CW-1:0]    count, count_next;
  logic [PW-1:0]    product_next;
  logic [WIDTH:0]   sum;

  // State, registered status decodes and datapath registers
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state   <= S_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      mcand   <= '0;
      acc     <= '0;
      mplier  <= '0;
      count   <= '0;
      product <= '0;
    end else begin
      state   <= state_next;
      busy    <= busy_next;
      done    <= done_next;
      mcand   <= mcand_next;
      acc     <= acc_next;
      mplier  <= mplier_next;
      count   <= count_next;
      product <= product_next;
    end
  end

  // Next-state, iteration datapath and status decodes
  always_comb begin
    state_next   = state;
    busy_next    = 1'b0;
    done_next    = 1'b0;
    mcand_next   = mcand;
    acc_next     = acc;
    mplier_next  = mplier;
    count_next   = count;
    product_next = product;
    // Carry-out lands in sum[WIDTH] and is shifted into acc, so nothing is lost
    sum = {1'b0, acc} + (mplier[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});

    case (state)
      S_IDLE: begin
        if (start) begin
          mcand_next  = a;
          acc_next    = '0;
          mplier_next = b;
          count_next  = '0;
          state_next  = S_RUN;
          busy_next   = 1'b1;
        end
      end
      S_RUN: begin
        acc_next    = sum[WIDTH:1];
        mplier_next = {sum[0], mplier[WIDTH-1:1]};
        count_next  = count + CW'(1);
        if (count == CW'(WIDTH - 1)) begin
          product_next = {acc_next, mplier_next};
          state_next   = S_DONE;
          done_next    = 1'b1;
        end else begin
          busy_next = 1'b1;
        end
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// Self-checking bench for seq_shift_add_multiplier (WIDTH=8 and WIDTH=4),
// comparing against plain a*b products and cycle-counted timing.
module tb_seq_shift_add_multiplier;

  logic        clk = 1'b0;
  logic        reset_;
  logic        start8, start4;
  logic [7:0]  a8, b8;
  logic [3:0]  a4, b4;
  logic        busy8, done8, busy4, done4;
  logic [15:0] product8;
  logic [7:0]  product4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_shift_add_multiplier #(.WIDTH(8)) dut8 (
    .clk(clk), .reset_(reset_), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .product(product8)
  );

  seq_shift_add_multiplier #(.WIDTH(4)) dut4 (
    .clk(clk), .reset_(reset_), .start(start4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .product(product4)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One WIDTH=8 multiply: accept, count cycles to done, check product and latency
  task automatic mul8(input logic [7:0] x, input logic [7:0] y, input string tag);
    int n;
    logic busy_ok;
    a8 = x; b8 = y; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    n = 0;
    busy_ok = 1'b1;
    while (!done8 && n < 40) begin
      if (busy8 !== 1'b1) busy_ok = 1'b0;
      @(posedge clk); #1;
      n++;
    end
    check({tag, " latency"}, 64'(n), 64'd8);
    check({tag, " busy_run"}, 64'(busy_ok), 64'd1);
    check({tag, " busy_at_done"}, 64'(busy8), 64'd0);
    check({tag, " product"}, 64'(product8), 64'(x) * 64'(y));
    @(posedge clk); #1;
    check({tag, " done_pulse_end"}, 64'(done8), 64'd0);
  endtask

  task automatic mul4(input logic [3:0] x, input logic [3:0] y, input bit full);
    int n;
    a4 = x; b4 = y; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    n = 0;
    while (!done4 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (full) check("w4 latency", 64'(n), 64'd4);
    check($sformatf("w4 %0d*%0d", x, y), 64'(product4), 64'(x) * 64'(y));
    @(posedge clk); #1;
  endtask

  initial begin
    int done_cnt;
    int done_edge[$];
    logic [15:0] done_prod[$];
    logic [7:0] rx, ry;

    reset_ = 1'b0;
    start8 = 1'b0; start4 = 1'b0;
    a8 = '0; b8 = '0; a4 = '0; b4 = '0;
    #2;
    check("reset busy8", 64'(busy8), 64'd0);
    check("reset done8", 64'(done8), 64'd0);
    check("reset product8", 64'(product8), 64'd0);
    check("reset product4", 64'(product4), 64'd0);
    #10 reset_ = 1'b1;

    // Basic directed product and hold
    mul8(8'd13, 8'd11, "13x11");
    repeat (12) @(posedge clk);
    #1 check("13x11 hold", 64'(product8), 64'd143);

    mul8(8'd255, 8'd255, "255x255");
    mul8(8'd0, 8'd200, "0x200");

    // Start held high: accepts at edges 0 and 10, done after edges 8 and 18
    a8 = 8'd3; b8 = 8'd5; start8 = 1'b1;
    @(posedge clk); #1;
    a8 = 8'd7; b8 = 8'd9;
    for (int e = 1; e <= 19; e++) begin
      @(posedge clk); #1;
      if (done8) begin
        done_edge.push_back(e);
        done_prod.push_back(product8);
      end
      if (e == 9)  check("held busy edge9", 64'(busy8), 64'd0);
      if (e == 10) check("held busy edge10", 64'(busy8), 64'd1);
    end
    start8 = 1'b0;
    check("held done count", 64'(done_edge.size()), 64'd2);
    if (done_edge.size() == 2) begin
      check("held done edge1", 64'(done_edge[0]), 64'd8);
      check("held done edge2", 64'(done_edge[1]), 64'd18);
      check("held product1", 64'(done_prod[0]), 64'd15);
      check("held product2", 64'(done_prod[1]), 64'd63);
    end
    @(posedge clk); #1;

    // Operand changes and start during RUN are ignored
    a8 = 8'd6; b8 = 8'd7; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    done_cnt = 0;
    for (int e = 1; e <= 20; e++) begin
      if (e == 2) begin a8 = 8'hFF; b8 = 8'hFF; start8 = 1'b1; end
      if (e == 3) start8 = 1'b0;
      @(posedge clk); #1;
      if (done8) done_cnt++;
    end
    check("ignore done count", 64'(done_cnt), 64'd1);
    check("ignore product", 64'(product8), 64'd42);

    // Asynchronous reset mid-RUN aborts without a done pulse
    a8 = 8'd100; b8 = 8'd100; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (4) @(posedge clk);
    #2 reset_ = 1'b0;
    #1;
    check("abort busy", 64'(busy8), 64'd0);
    check("abort done", 64'(done8), 64'd0);
    check("abort product", 64'(product8), 64'd0);
    @(negedge clk) reset_ = 1'b1;
    done_cnt = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done8 || busy8) done_cnt++;
    end
    check("abort no done", 64'(done_cnt), 64'd0);
    mul8(8'd2, 8'd3, "2x3");

    // Random operand pairs against a*b
    for (int i = 0; i < 16; i++) begin
      rx = 8'($urandom);
      ry = 8'($urandom);
      mul8(rx, ry, $sformatf("rand%0d", i));
    end

    // WIDTH=4: corner and full sweep
    mul4(4'd15, 4'd15, 1'b1);
    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++)
        mul4(4'(i), 4'(j), 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
